rob: RTL
========

Name: rob

Overview:
- Reorder buffer. Sits directly downstream of the ALU reservation stations and the CDB.
- Allocates a tag per dispatched instruction and captures results broadcast on the CDB.
- Retires instructions in program order to the architectural register file.
- Also answers dispatch-time operand lookups, which is where the RS rs*_rob / rs*_ready / rs*_v fields come from.

Parameters:
ROB_DEPTH, 3, log2 of entry count (8 entries); tag width = ROB_DEPTH bits.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
flush  input  1  synchronous clear of all entries (mispredict recovery)
dispatch_valid  input  1  allocate one entry this cycle
dispatch_rd  input  5  destination architectural register (x0 allowed)
dispatch_ready  output  1  entry available (not full)
dispatch_tag  output  ROB_DEPTH  tag that the current dispatch receives (= tail)
rs1_query_tag  input  ROB_DEPTH  tag to look up for operand 1
rs1_query_ready  output  1  queried entry holds a result
rs1_query_value  output  32  queried result
rs2_query_tag  input  ROB_DEPTH  tag to look up for operand 2
rs2_query_ready  output  1  queried entry holds a result
rs2_query_value  output  32  queried result
cdb_valid  input  1  result broadcast
cdb_tag  input  ROB_DEPTH  producing entry
cdb_value  input  32  result
commit_valid  output  1  head retires this cycle
commit_rd  output  5  retiring destination
commit_value  output  32  retiring value
commit_tag  output  ROB_DEPTH  retiring tag (rename-table clear match)
count  output  ROB_DEPTH+1  occupied entries

Behaviour:
- Storage: per entry valid, ready, rd[4:0], value[31:0]. head and tail pointers are ROB_DEPTH bits with natural wrap; count is ROB_DEPTH+1 bits. full = (count == 2**ROB_DEPTH), empty = (count == 0).
- Reset (async): head = tail = 0, count = 0, all valid/ready = 0, values = 0. All outputs are then 0 except dispatch_ready = 1.
- Dispatch:
  - dispatch_ready = !full, computed from registered state only. No credit is given for a commit in the same cycle.
  - dispatch_tag = tail.
  - When dispatch_valid && dispatch_ready: the entry at tail gets valid = 1, ready = 0, rd = dispatch_rd, and tail increments.
  - dispatch_valid while full is ignored, with no state change. The bench flags it as a protocol violation.
- Writeback: when cdb_valid and entry[cdb_tag].valid, set ready = 1 and value = cdb_value on the next edge. A CDB to an invalid entry is ignored.
- Commit:
  - commit_valid = entry[head].valid && entry[head].ready, combinational from registers.
  - commit_rd, commit_value and commit_tag are driven from the head entry. When commit_valid = 0 they are held at 0.
  - On commit: entry[head].valid = 0, head increments.
- Latency: dispatch to earliest commit is 2 cycles. A CDB write lands at the edge and commit is visible the following cycle; there is no CDB-to-commit bypass.
- Query:
  - Combinational. ready = entry.ready || (cdb_valid && cdb_tag == query_tag).
  - value comes from the CDB on a match, otherwise from the entry.
  - The CDB forward takes priority even if the entry is already ready.
- Simultaneous events:
  - Dispatch + commit in one cycle: count unchanged, and both pointers advance.
  - Dispatch to an entry being committed the same cycle is impossible, because tail == head only when empty or full.
  - A CDB write to the head in the same cycle it becomes ready commits in the next cycle.
- Wrap-around: the pointers roll from 2**ROB_DEPTH-1 to 0 with no special handling.
- Flush:
  - Takes effect on the next edge: head = tail = count = 0 and all valid = 0.
  - Flush overrides dispatch, CDB and commit in the same cycle. The commit outputs still show the head that cycle, but the consumer must qualify them with !flush.
- Reset mid-operation: asynchronous assertion returns to the reset state immediately, with outputs following combinationally.

Decomposition:
- Shared package (rv32i_types): rob_entry_t struct {valid, ready, rd, value}; typedef rob_tag_t = logic [ROB_DEPTH-1:0]; constant ROB_NUM_ELEMS = 2**ROB_DEPTH. The ALU RS imports rob_tag_t for its rs*_rob fields.
- No sub-module. The two query ports share one combinational lookup function in the package.

Test Plan:
- Reset then idle: after rst drops, dispatch_ready = 1, count = 0, commit_valid = 0, dispatch_tag = 0.
- Fill: 8 dispatches with rd = 1..8 and no CDB → count = 8, dispatch_ready = 0. A 9th dispatch_valid changes nothing and tail stays 0.
- Out-of-order completion: CDB tag 2 = 0x22 first, then tag 0 = 0x00, then tag 1 = 0x11. Commits appear as tags 0, 1, 2 with values 0x00, 0x11, 0x22 on consecutive cycles, and none before tag 0 is ready.
- Query forward: with tag 3 pending, drive cdb_tag = 3, value 0xDEADBEEF, rs1_query_tag = 3 in the same cycle → rs1_query_ready = 1 and rs1_query_value = 0xDEADBEEF. On the next cycle the entry path returns the same value.
- Full plus commit: ROB full with head ready. Dispatch_ready stays 0 that cycle. After the commit, dispatch_ready = 1, a dispatch gets tag 0 (wrapped), and count = 8.
- Flush and async reset: with 5 entries and a CDB pending, assert flush → next cycle count = 0 and the CDB write is dropped. Assert rst asynchronously mid-cycle → outputs go to reset values before the next edge.

Source files
------------

// File: rtl/rv32i_types.sv
// rv32i_types: shared reorder-buffer types and the operand lookup used by both query ports.
package rv32i_types;
   localparam int ROB_DEPTH = 3;
   localparam int ROB_NUM_ELEMS = 2**ROB_DEPTH;
   typedef logic [ROB_DEPTH-1:0] rob_tag_t;
   typedef struct packed {
      logic        valid;
      logic        ready;
      logic [4:0]  rd;
      logic [31:0] value;
   } rob_entry_t;
   // A same-cycle CDB broadcast wins over the stored entry, so dispatch never misses a result.
   function automatic logic [32:0] rob_lookup(input rob_entry_t e, input logic cdb_valid,
                                              input rob_tag_t cdb_tag, input logic [31:0] cdb_value,
                                              input rob_tag_t tag);
      return (cdb_valid && cdb_tag == tag) ? {1'b1, cdb_value} : {e.ready, e.value};
   endfunction
endpackage

// File: rtl/rob.sv
// rob: reorder buffer; allocates tags, captures CDB results, retires in program order.
module rob import rv32i_types::*; (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 dispatch_valid,
   input  logic [4:0]           dispatch_rd,
   output logic                 dispatch_ready,
   output logic [ROB_DEPTH-1:0] dispatch_tag,
   input  logic [ROB_DEPTH-1:0] rs1_query_tag,
   output logic                 rs1_query_ready,
   output logic [31:0]          rs1_query_value,
   input  logic [ROB_DEPTH-1:0] rs2_query_tag,
   output logic                 rs2_query_ready,
   output logic [31:0]          rs2_query_value,
   input  logic                 cdb_valid,
   input  logic [ROB_DEPTH-1:0] cdb_tag,
   input  logic [31:0]          cdb_value,
   output logic                 commit_valid,
   output logic [4:0]           commit_rd,
   output logic [31:0]          commit_value,
   output logic [ROB_DEPTH-1:0] commit_tag,
   output logic [ROB_DEPTH:0]   count
);
   rob_entry_t ent [ROB_NUM_ELEMS];
   rob_tag_t head, tail;
   logic full, do_dispatch;
   // count never exceeds ROB_NUM_ELEMS, so its top bit alone marks full
   assign full = count[ROB_DEPTH];
   assign dispatch_ready = !full;
   assign dispatch_tag = tail;
   assign do_dispatch = dispatch_valid && !full;
   assign commit_valid = ent[head].valid && ent[head].ready;
   assign commit_rd = commit_valid ? ent[head].rd : '0;
   assign commit_value = commit_valid ? ent[head].value : '0;
   assign commit_tag = commit_valid ? head : '0;
   assign {rs1_query_ready, rs1_query_value} = rob_lookup(ent[rs1_query_tag], cdb_valid, cdb_tag, cdb_value, rs1_query_tag);
   assign {rs2_query_ready, rs2_query_value} = rob_lookup(ent[rs2_query_tag], cdb_valid, cdb_tag, cdb_value, rs2_query_tag);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         count <= '0;
         for (int i = 0; i < ROB_NUM_ELEMS; i++) ent[i] <= '0;
      end else if (flush) begin
         head <= '0;
         tail <= '0;
         count <= '0;
         for (int i = 0; i < ROB_NUM_ELEMS; i++) ent[i].valid <= 1'b0;
      end else begin
         if (cdb_valid && ent[cdb_tag].valid) begin
            ent[cdb_tag].ready <= 1'b1;
            ent[cdb_tag].value <= cdb_value;
         end
         if (do_dispatch) begin
            ent[tail].valid <= 1'b1;
            ent[tail].ready <= 1'b0;
            ent[tail].rd <= dispatch_rd;
         end
         if (commit_valid) ent[head].valid <= 1'b0;
         head <= head + rob_tag_t'(commit_valid);
         tail <= tail + rob_tag_t'(do_dispatch);
         count <= count + (ROB_DEPTH+1)'(do_dispatch) - (ROB_DEPTH+1)'(commit_valid);
      end
   end
endmodule
